// File: rtl/touch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : touch_pkg
//  Description : Shared types and default geometry for the touch decoder.
//                The state and hit-class enums live here so the decoder and
//                any environment that watches it agree on the encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package touch_pkg;

    // Decoder state machine
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        HELD   = 3'd2,
        DECODE = 3'd3,
        WRITE  = 3'd4
    } state_t;

    // Classification of a latched touch point
    typedef enum logic [2:0] {
        HIT_NONE  = 3'd0,
        HIT_TEXT  = 3'd1,
        HIT_MINUS = 3'd2,
        HIT_BAR   = 3'd3,
        HIT_PLUS  = 3'd4
    } hit_class_t;

    // Default configuration and screen geometry
    localparam int DEF_COORD_W   = 8;
    localparam int DEF_N_SLIDERS = 2;
    localparam int DEF_SLIDE_MAX = 127;
    localparam int DEF_DEBOUNCE  = 3;
    localparam int DEF_REL_CYC   = 8;
    localparam int DEF_TXT_X0    = 7;
    localparam int DEF_TXT_Y0    = 7;
    localparam int DEF_CELL_W    = 19;
    localparam int DEF_CELL_H    = 8;
    localparam int DEF_TXT_COLS  = 12;
    localparam int DEF_TXT_ROWS  = 16;
    localparam int DEF_BAR_X0    = 40;
    localparam int DEF_BAR_X1    = 220;
    localparam int DEF_MIN_X0    = 20;
    localparam int DEF_PLS_X1    = 240;
    localparam int DEF_SL_Y0     = 155;
    localparam int DEF_SL_H      = 14;
    localparam int DEF_SL_PITCH  = 20;

endpackage
`default_nettype wire

// File: rtl/touch_if.sv
`default_nettype none
// ============================================================================
//  Module      : touch_if
//  Description : Coordinate input, slider preset and decoded-result bundle
//                between a touch controller front end and touch_decode.
//                slave = decoder side, master = driver/observer side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface touch_if #(
    parameter int COORD_W = 8,
    parameter int CH_W    = 1,
    parameter int SV_W    = 7
);
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               new_coord;
    logic               slide_load;
    logic [CH_W-1:0]    slide_load_ch;
    logic [SV_W-1:0]    slide_load_val;
    logic [3:0]         cell_col;
    logic [3:0]         cell_row;
    logic               cell_valid;
    logic [CH_W-1:0]    slide_ch;
    logic [SV_W-1:0]    slide_val;
    logic               write_slide;
    logic [COORD_W-1:0] hit_x;
    logic [COORD_W-1:0] hit_y;
    logic               busy;

    modport slave (
        input  x, y, new_coord, slide_load, slide_load_ch, slide_load_val,
        output cell_col, cell_row, cell_valid, slide_ch, slide_val,
               write_slide, hit_x, hit_y, busy
    );

    modport master (
        output x, y, new_coord, slide_load, slide_load_ch, slide_load_val,
        input  cell_col, cell_row, cell_valid, slide_ch, slide_val,
               write_slide, hit_x, hit_y, busy
    );
endinterface
`default_nettype wire

// File: rtl/touch_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : touch_debounce
//  Description : Pen-down synchroniser plus the press (strobe) and release
//                counters. touch_ok/latch fire on the strobe that completes
//                the press; release_ok fires on the last of REL_CYC
//                consecutive pen-up cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module touch_debounce #(
    parameter int DEBOUNCE = 3,
    parameter int REL_CYC  = 8
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic penirq_n,
    input  wire logic new_coord,
    input  wire logic strobe_clr,   // counting restarts from zero this cycle
    input  wire logic strobe_en,    // strobes are being counted
    input  wire logic rel_en,       // release cycles are being counted
    output logic      pen_dn,
    output logic      touch_ok,
    output logic      release_ok,
    output logic      latch
);

    localparam int SC_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
    localparam int RC_W = (REL_CYC  > 1) ? $clog2(REL_CYC  + 1) : 1;

    logic [1:0]      sync_ff;
    logic [SC_W-1:0] strobe_cnt;
    logic [SC_W-1:0] strobe_base;
    logic            strobe_hit;
    logic [RC_W-1:0] rel_cnt;

    assign pen_dn      = ~sync_ff[1];
    assign strobe_base = strobe_clr ? '0 : strobe_cnt;
    assign strobe_hit  = strobe_en & new_coord & pen_dn;
    assign touch_ok    = strobe_hit & ((32'(strobe_base) + 32'd1) >= 32'(DEBOUNCE));
    assign latch       = touch_ok;
    assign release_ok  = rel_en & ~pen_dn & (32'(rel_cnt) == 32'(REL_CYC - 1));

    // Two-flop synchroniser; idles at 1 (pen up)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_ff <= 2'b11;
        else        sync_ff <= {sync_ff[0], penirq_n};
    end

    // Press counter: counts pen-down strobes, reset once the press is confirmed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          strobe_cnt <= '0;
        else if (touch_ok)   strobe_cnt <= '0;
        else if (strobe_hit) strobe_cnt <= strobe_base + SC_W'(1);
        else if (strobe_clr) strobe_cnt <= '0;
    end

    // Release counter: any pen-down cycle restarts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          rel_cnt <= '0;
        else if (!rel_en || pen_dn || release_ok) rel_cnt <= '0;
        else                                 rel_cnt <= rel_cnt + RC_W'(1);
    end

endmodule
`default_nettype wire

// File: rtl/touch_decode.sv
`default_nettype none
// ============================================================================
//  Module      : touch_decode
//  Description : Debounces a resistive-touch press, latches the touch point
//                and on release classifies it as a text-cell hit or a
//                slider minus/bar/plus hit, updating the slider store.
//                Optional build macro TOUCH_DRAG_EN: bar strobes while held
//                update the slider live and suppress the release write.
//  Revision    : 1.0 - initial release
// ============================================================================
module touch_decode
    import touch_pkg::*;
#(
    parameter int COORD_W   = DEF_COORD_W,
    parameter int N_SLIDERS = DEF_N_SLIDERS,
    parameter int SLIDE_MAX = DEF_SLIDE_MAX,
    parameter int DEBOUNCE  = DEF_DEBOUNCE,
    parameter int REL_CYC   = DEF_REL_CYC,
    parameter int TXT_X0    = DEF_TXT_X0,
    parameter int TXT_Y0    = DEF_TXT_Y0,
    parameter int CELL_W    = DEF_CELL_W,
    parameter int CELL_H    = DEF_CELL_H,
    parameter int TXT_COLS  = DEF_TXT_COLS,
    parameter int TXT_ROWS  = DEF_TXT_ROWS,
    parameter int BAR_X0    = DEF_BAR_X0,
    parameter int BAR_X1    = DEF_BAR_X1,
    parameter int MIN_X0    = DEF_MIN_X0,
    parameter int PLS_X1    = DEF_PLS_X1,
    parameter int SL_Y0     = DEF_SL_Y0,
    parameter int SL_H      = DEF_SL_H,
    parameter int SL_PITCH  = DEF_SL_PITCH
) (
    input  wire logic sys_clk,
    input  wire logic iRST_n,
    input  wire logic penirq_n,
    touch_if.slave    bus
);

    localparam int CH_W = (N_SLIDERS > 1) ? $clog2(N_SLIDERS) : 1;
    localparam int SV_W = $clog2(SLIDE_MAX + 1);

    state_t             state, state_nx;
    logic               pen_dn, touch_ok, release_ok, latch;
    logic               strobe_clr, strobe_en, rel_en;
    logic [COORD_W-1:0] hit_x, hit_y;
    logic [3:0]         cell_col, cell_row;
    logic               cell_valid, write_slide;
    logic [CH_W-1:0]    slide_ch;
    logic [SV_W-1:0]    store [0:N_SLIDERS-1];
    hit_class_t         dec_cls;
    logic [CH_W-1:0]    dec_ch;
    logic [SV_W-1:0]    cur_val;
    logic               tw_en;
    logic [CH_W-1:0]    tw_ch;
    logic [SV_W-1:0]    tw_val;
    logic [SV_W-1:0]    load_val;
    logic               dragged;

    // Classify a coordinate: text area first, then slider rows (lowest channel wins)
    function automatic void classify(input logic [COORD_W-1:0] px,
                                     input logic [COORD_W-1:0] py,
                                     output hit_class_t cls,
                                     output logic [CH_W-1:0] ch);
        logic [31:0] ux, uy;
        logic        on_row;
        ux     = 32'(px);
        uy     = 32'(py);
        cls    = HIT_NONE;
        ch     = '0;
        on_row = 1'b0;
        if (ux >= 32'(TXT_X0) && ux < 32'(TXT_X0 + TXT_COLS * CELL_W) &&
            uy >= 32'(TXT_Y0) && uy < 32'(TXT_Y0 + TXT_ROWS * CELL_H)) begin
            cls = HIT_TEXT;
        end else begin
            for (int k = N_SLIDERS - 1; k >= 0; k--) begin
                if (uy >= 32'(SL_Y0 + k * SL_PITCH) &&
                    uy <= 32'(SL_Y0 + k * SL_PITCH + SL_H - 1)) begin
                    on_row = 1'b1;
                    ch     = CH_W'(k);
                end
            end
            if (on_row) begin
                if (ux >= 32'(MIN_X0) && ux < 32'(BAR_X0))       cls = HIT_MINUS;
                else if (ux >= 32'(BAR_X0) && ux <= 32'(BAR_X1)) cls = HIT_BAR;
                else if (ux > 32'(BAR_X1) && ux <= 32'(PLS_X1))  cls = HIT_PLUS;
            end
        end
    endfunction

    // Bar position to value; 32-bit intermediate covers COORD_W + SV_W + 1 bits
    function automatic logic [SV_W-1:0] bar_value(input logic [COORD_W-1:0] px);
        logic [31:0] q;
        q = ((32'(px) - 32'(BAR_X0)) * 32'(SLIDE_MAX + 1)) / 32'(BAR_X1 - BAR_X0 + 1);
        return (q > 32'(SLIDE_MAX)) ? SV_W'(SLIDE_MAX) : SV_W'(q);
    endfunction

    touch_debounce #(
        .DEBOUNCE (DEBOUNCE),
        .REL_CYC  (REL_CYC)
    ) u_debounce (
        .clk        (sys_clk),
        .rst_n      (iRST_n),
        .penirq_n   (penirq_n),
        .new_coord  (bus.new_coord),
        .strobe_clr (strobe_clr),
        .strobe_en  (strobe_en),
        .rel_en     (rel_en),
        .pen_dn     (pen_dn),
        .touch_ok   (touch_ok),
        .release_ok (release_ok),
        .latch      (latch)
    );

    // State register
    always_ff @(posedge sys_clk or negedge iRST_n) begin
        if (!iRST_n) state <= IDLE;
        else         state <= state_nx;
    end

    // Next state and debounce counter controls
    always_comb begin
        state_nx   = state;
        strobe_clr = 1'b0;
        strobe_en  = 1'b0;
        rel_en     = 1'b0;
        case (state)
            IDLE: begin
                strobe_clr = 1'b1;
                strobe_en  = 1'b1;
                if (touch_ok)                     state_nx = HELD;
                else if (bus.new_coord && pen_dn) state_nx = ARM;
            end
            ARM: begin
                strobe_en = 1'b1;
                rel_en    = 1'b1;
                if (touch_ok)        state_nx = HELD;
                else if (release_ok) state_nx = IDLE;
            end
            HELD: begin
                rel_en = 1'b1;
                if (release_ok) state_nx = DECODE;
            end
            DECODE:  state_nx = WRITE;
            WRITE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

`ifdef TOUCH_DRAG_EN
    hit_class_t      in_cls;
    logic [CH_W-1:0] in_ch;
    logic [CH_W-1:0] drag_ch;
    logic            drag_valid;
    logic            dragged_r;

    assign dragged = dragged_r;

    // Remember the slider row of the press; note when a live drag has written
    always_ff @(posedge sys_clk or negedge iRST_n) begin
        if (!iRST_n) begin
            drag_ch    <= '0;
            drag_valid <= 1'b0;
            dragged_r  <= 1'b0;
        end else if (latch) begin
            drag_ch    <= in_ch;
            drag_valid <= (in_cls == HIT_MINUS) || (in_cls == HIT_BAR) || (in_cls == HIT_PLUS);
            dragged_r  <= 1'b0;
        end else if (state == HELD && tw_en) begin
            dragged_r  <= 1'b1;
        end
    end
`else
    assign dragged = 1'b0;
`endif

    // Slider store update requested by a decoded release or a live drag
    always_comb begin
        tw_en   = 1'b0;
        tw_ch   = '0;
        tw_val  = '0;
        dec_cls = HIT_NONE;
        dec_ch  = '0;
        classify(hit_x, hit_y, dec_cls, dec_ch);
        cur_val = store[dec_ch];
        if (state == DECODE && !dragged) begin
            case (dec_cls)
                HIT_MINUS: begin
                    tw_en  = 1'b1;
                    tw_ch  = dec_ch;
                    tw_val = (cur_val == '0) ? '0 : cur_val - SV_W'(1);
                end
                HIT_BAR: begin
                    tw_en  = 1'b1;
                    tw_ch  = dec_ch;
                    tw_val = bar_value(hit_x);
                end
                HIT_PLUS: begin
                    tw_en  = 1'b1;
                    tw_ch  = dec_ch;
                    tw_val = (32'(cur_val) >= 32'(SLIDE_MAX)) ? SV_W'(SLIDE_MAX)
                                                              : cur_val + SV_W'(1);
                end
                default: ;
            endcase
        end
`ifdef TOUCH_DRAG_EN
        in_cls = HIT_NONE;
        in_ch  = '0;
        classify(bus.x, bus.y, in_cls, in_ch);
        if (state == HELD && bus.new_coord && pen_dn && drag_valid &&
            in_cls == HIT_BAR && in_ch == drag_ch) begin
            tw_en  = 1'b1;
            tw_ch  = drag_ch;
            tw_val = bar_value(bus.x);
        end
`endif
    end

    assign load_val = (32'(bus.slide_load_val) > 32'(SLIDE_MAX)) ? SV_W'(SLIDE_MAX)
                                                                 : bus.slide_load_val;

    // Channel store: a touch update takes priority over an external preset
    always_ff @(posedge sys_clk or negedge iRST_n) begin
        if (!iRST_n) begin
            for (int i = 0; i < N_SLIDERS; i++) store[i] <= '0;
        end else begin
            for (int i = 0; i < N_SLIDERS; i++) begin
                if (tw_en && tw_ch == CH_W'(i))
                    store[i] <= tw_val;
                else if (bus.slide_load && bus.slide_load_ch == CH_W'(i))
                    store[i] <= load_val;
            end
        end
    end

    // Latched touch point and result registers; pulses are high for one cycle
    always_ff @(posedge sys_clk or negedge iRST_n) begin
        if (!iRST_n) begin
            hit_x       <= '0;
            hit_y       <= '0;
            cell_col    <= '0;
            cell_row    <= '0;
            cell_valid  <= 1'b0;
            slide_ch    <= '0;
            write_slide <= 1'b0;
        end else begin
            if (latch) begin
                hit_x <= bus.x;
                hit_y <= bus.y;
            end
            cell_valid <= (state == DECODE) && (dec_cls == HIT_TEXT);
            if (state == DECODE && dec_cls == HIT_TEXT) begin
                cell_col <= 4'((32'(hit_x) - 32'(TXT_X0)) / 32'(CELL_W));
                cell_row <= 4'((32'(hit_y) - 32'(TXT_Y0)) / 32'(CELL_H));
            end
            write_slide <= tw_en;
            if (tw_en) slide_ch <= tw_ch;
        end
    end

    assign bus.hit_x       = hit_x;
    assign bus.hit_y       = hit_y;
    assign bus.cell_col    = cell_col;
    assign bus.cell_row    = cell_row;
    assign bus.cell_valid  = cell_valid;
    assign bus.slide_ch    = slide_ch;
    assign bus.slide_val   = store[slide_ch];
    assign bus.write_slide = write_slide;
    assign bus.busy        = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_touch_decode.sv
`default_nettype none
// ============================================================================
//  Module      : tb_touch_decode
//  Description : Scoreboard bench for touch_decode. Stimulus pushes the
//                expected cell/slider event; a monitor pops and compares on
//                every cell_valid or write_slide pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_touch_decode;
    import touch_pkg::*;

    localparam int COORD_W = 8;
    localparam int CH_W    = 1;
    localparam int SV_W    = 7;

    typedef struct {
        bit is_cell;
        int a;      // cell_col or slide_ch
        int b;      // cell_row or slide_val
    } exp_t;

    logic sys_clk  = 1'b0;
    logic iRST_n   = 1'b0;
    logic penirq_n = 1'b1;
    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    touch_if #(.COORD_W(COORD_W), .CH_W(CH_W), .SV_W(SV_W)) bus ();

    touch_decode dut (
        .sys_clk  (sys_clk),
        .iRST_n   (iRST_n),
        .penirq_n (penirq_n),
        .bus      (bus)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic strobe(input int px, input int py);
        bus.x         = COORD_W'(px);
        bus.y         = COORD_W'(py);
        bus.new_coord = 1'b1;
        @(negedge sys_clk);
        bus.new_coord = 1'b0;
        tick(3);
    endtask

    task automatic touch(input int px, input int py, input int n);
        penirq_n = 1'b0;
        tick(4);
        repeat (n) strobe(px, py);
        penirq_n = 1'b1;
        tick(20);
    endtask

    task automatic load(input int ch, input int val);
        bus.slide_load     = 1'b1;
        bus.slide_load_ch  = CH_W'(ch);
        bus.slide_load_val = SV_W'(val);
        @(negedge sys_clk);
        bus.slide_load     = 1'b0;
    endtask

    task automatic expect_cell(input int col, input int row);
        exp_q.push_back('{1'b1, col, row});
    endtask

    task automatic expect_slide(input int ch, input int val);
        exp_q.push_back('{1'b0, ch, val});
    endtask

    // Monitor: every pulse cycle must match the oldest pending expectation
    always @(negedge sys_clk) begin
        if (iRST_n && (bus.cell_valid || bus.write_slide)) begin
            check("pulse_expected", (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pulse_kind_cell", int'(bus.cell_valid), e.is_cell ? 1 : 0);
                check("pulse_kind_slide", int'(bus.write_slide), e.is_cell ? 0 : 1);
                if (e.is_cell) begin
                    check("cell_col", int'(bus.cell_col), e.a);
                    check("cell_row", int'(bus.cell_row), e.b);
                end else begin
                    check("slide_ch", int'(bus.slide_ch), e.a);
                    check("slide_val", int'(bus.slide_val), e.b);
                end
            end
        end
    end

    initial begin
        bus.x              = '0;
        bus.y              = '0;
        bus.new_coord      = 1'b0;
        bus.slide_load     = 1'b0;
        bus.slide_load_ch  = '0;
        bus.slide_load_val = '0;
        tick(3);

        // Reset state
        check("rst_busy",        int'(bus.busy), 0);
        check("rst_hit_x",       int'(bus.hit_x), 0);
        check("rst_hit_y",       int'(bus.hit_y), 0);
        check("rst_cell_col",    int'(bus.cell_col), 0);
        check("rst_cell_valid",  int'(bus.cell_valid), 0);
        check("rst_write_slide", int'(bus.write_slide), 0);
        check("rst_slide_ch",    int'(bus.slide_ch), 0);
        check("rst_slide_val",   int'(bus.slide_val), 0);
        iRST_n = 1'b1;
        tick(2);

        // Text cells, including the area corners
        expect_cell(2, 2);
        touch(45, 23, 3);
        check("hit_x_text", int'(bus.hit_x), 45);
        check("hit_y_text", int'(bus.hit_y), 23);
        check("cell_col_hold", int'(bus.cell_col), 2);
        check("busy_idle", int'(bus.busy), 0);
        expect_cell(0, 0);
        touch(7, 7, 3);
        expect_cell(11, 15);
        touch(234, 134, 3);

        // Bar hit
        expect_slide(0, 47);
        touch(107, 160, 3);
        check("slide_val_hold", int'(bus.slide_val), 47);

        // Plus / minus with saturation and normal stepping
        load(1, 127);
        expect_slide(1, 127);
        touch(230, 180, 3);
        load(1, 5);
        expect_slide(1, 6);
        touch(230, 180, 3);
        load(0, 0);
        expect_slide(0, 0);
        touch(25, 160, 3);
        load(0, 10);
        expect_slide(0, 9);
        touch(25, 160, 3);

        // Bar ends
        expect_slide(1, 127);
        touch(220, 175, 3);
        expect_slide(0, 0);
        touch(40, 168, 3);

        // Preset held across the touch write: touch wins, preset resumes after
        bus.slide_load     = 1'b1;
        bus.slide_load_ch  = 1'b0;
        bus.slide_load_val = 7'd99;
        expect_slide(0, 47);
        touch(107, 160, 3);
        bus.slide_load = 1'b0;
        tick(1);
        check("load_after_write", int'(bus.slide_val), 99);

        // Minus edge column, plus edge column on channel 1
        expect_slide(0, 98);
        touch(39, 168, 3);
        expect_slide(1, 127);
        touch(240, 188, 3);

        // No-hit points: just outside text area and just past plus
        touch(235, 23, 3);
        touch(241, 160, 3);
        check("hit_x_none", int'(bus.hit_x), 241);

        // Aborted press: only two strobes
        touch(60, 60, 2);
        check("abort_hit_x", int'(bus.hit_x), 241);
        check("abort_busy", int'(bus.busy), 0);

        // Reset while HELD
        penirq_n = 1'b0;
        tick(4);
        repeat (3) strobe(45, 23);
        check("held_busy", int'(bus.busy), 1);
        iRST_n = 1'b0;
        tick(2);
        check("mid_rst_busy",     int'(bus.busy), 0);
        check("mid_rst_hit_x",    int'(bus.hit_x), 0);
        check("mid_rst_cell_col", int'(bus.cell_col), 0);
        check("mid_rst_cell_row", int'(bus.cell_row), 0);
        check("mid_rst_slide_ch", int'(bus.slide_ch), 0);
        check("mid_rst_slide_val", int'(bus.slide_val), 0);
        penirq_n = 1'b1;
        tick(2);
        iRST_n = 1'b1;
        tick(20);
        check("post_rst_busy", int'(bus.busy), 0);

`ifdef TOUCH_DRAG_EN
        // Drag along channel 0 bar
        penirq_n = 1'b0;
        tick(4);
        repeat (3) strobe(40, 160);
        expect_slide(0, 0);
        expect_slide(0, 63);
        expect_slide(0, 127);
        strobe(40, 160);
        strobe(130, 160);
        strobe(220, 160);
        penirq_n = 1'b1;
        tick(20);
        check("drag_final_val", int'(bus.slide_val), 127);
`endif

        check("all_events_seen", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/touch_decode.md
TOUCH_DECODE -- requirements
Module: touch_decode

Interface
REQ-001 The module SHALL have parameter COORD_W, default 8, meaning the width of the x and y coordinates.
REQ-002 The module SHALL have parameter N_SLIDERS, default 2, meaning the number of independent slider channels.
REQ-003 The module SHALL have parameter SLIDE_MAX, default 127, meaning the maximum value of any slider.
REQ-004 The module SHALL have parameter DEBOUNCE, default 3, meaning the number of pen-down coordinate strobes that confirm a touch.
REQ-005 The module SHALL have parameter REL_CYC, default 8, meaning the number of stable pen-up sys_clk cycles that confirm a release.
REQ-006 The module SHALL have geometry parameters TXT_X0=7, TXT_Y0=7, CELL_W=19, CELL_H=8, TXT_COLS=12, TXT_ROWS=16, BAR_X0=40, BAR_X1=220, MIN_X0=20, PLS_X1=240, SL_Y0=155, SL_H=14 and SL_PITCH=20.
REQ-007 sys_clk  in  1  is the single clock.
REQ-008 iRST_n  in  1  is the reset, asynchronous and active-low.
REQ-009 x, y  in  COORD_W each  carry the current touch coordinate.
REQ-010 new_coord  in  1  is a one-cycle strobe meaning x and y are valid.
REQ-011 penirq_n  in  1  is the asynchronous pen-down indication, active-low.
REQ-012 slide_load, slide_load_ch, slide_load_val  in  1 / CH_W / SV_W  provide an external preset of one slider channel.
REQ-013 cell_col, cell_row, cell_valid  out  4 / 4 / 1  report the selected text cell, with cell_valid as a one-cycle pulse.
REQ-014 slide_ch, slide_val, write_slide  out  CH_W / SV_W / 1  report the active slider channel, its value, and a one-cycle write pulse.
REQ-015 hit_x, hit_y  out  COORD_W each  report the latched touch point.
REQ-016 busy  out  1  is high whenever the state machine is not in IDLE.
REQ-017 CH_W SHALL be $clog2(N_SLIDERS) with a minimum of 1, and SV_W SHALL be $clog2(SLIDE_MAX+1).

Function
REQ-018 penirq_n SHALL pass through a 2-flop synchroniser, giving pen_dn; all logic SHALL use pen_dn.
REQ-019 The state machine SHALL have the states IDLE, ARM, HELD, DECODE and WRITE.
REQ-020 IDLE SHALL go to ARM on the first new_coord with pen_dn set, clearing the strobe counter and then counting that strobe.
REQ-021 In ARM, the counter SHALL increment on each new_coord with pen_dn; on reaching DEBOUNCE it SHALL latch hit_x/hit_y from that strobe and go to HELD.
REQ-022 In ARM, pen_dn low for REL_CYC cycles SHALL return the machine to IDLE with no output and hit_x/hit_y unchanged.
REQ-023 In HELD, pen_dn low for REL_CYC consecutive cycles SHALL move the machine to DECODE; any pen_dn high SHALL restart the release count.
REQ-024 DECODE SHALL classify the hit in priority order: text area, slider row, none; it SHALL take exactly 1 cycle and then go to WRITE.
REQ-025 The hit is in the text area when TXT_X0<=hit_x<TXT_X0+TXT_COLS*CELL_W and TXT_Y0<=hit_y<TXT_Y0+TXT_ROWS*CELL_H.
REQ-026 For a text-area hit, cell_col SHALL be (hit_x-TXT_X0)/CELL_W and cell_row SHALL be (hit_y-TXT_Y0)/CELL_H.
REQ-027 Slider channel k SHALL span y from SL_Y0+k*SL_PITCH to SL_Y0+k*SL_PITCH+SL_H-1, for k<N_SLIDERS.
REQ-028 Within a slider row, the x ranges SHALL be: minus MIN_X0..BAR_X0-1, bar BAR_X0..BAR_X1, plus BAR_X1+1..PLS_X1.
REQ-029 A bar hit SHALL set value=((hit_x-BAR_X0)*(SLIDE_MAX+1))/(BAR_X1-BAR_X0+1), clamped to SLIDE_MAX, with an intermediate width sufficient to avoid overflow.
REQ-030 Minus SHALL decrement the value, saturating at 0; plus SHALL increment it, saturating at SLIDE_MAX.
REQ-031 WRITE SHALL last 1 cycle: a text hit pulses cell_valid; a slider hit updates the channel store, drives slide_ch/slide_val and pulses write_slide; none produces no pulse; WRITE then goes to IDLE.
REQ-032 Each channel value SHALL be held in an internal array of N_SLIDERS by SV_W bits.
REQ-033 slide_load SHALL write slide_load_val (clamped) to the store; if it coincides with a WRITE to the same channel, the touch update SHALL win; a slide_load_ch out of range SHALL be ignored.
REQ-034 slide_val SHALL always show the store entry of the current slide_ch.
REQ-035 cell_col, cell_row and slide_ch SHALL hold their values between events.

Reset
REQ-036 While iRST_n is low, the state SHALL be IDLE, all counters 0, hit_x/hit_y 0, cell_* 0, cell_valid 0, write_slide 0, slide_ch 0, all store entries 0, busy 0 and the synchroniser 1.
REQ-037 Reset asserted mid-operation SHALL abort the operation with no pulse emitted after deassertion.

Configuration
REQ-038 With TOUCH_DRAG_EN defined, each new_coord in HELD whose coordinate lies on the bar of the channel latched at HELD entry SHALL update that channel and pulse write_slide one cycle later; the release path SHALL then emit no second slider write.
REQ-039 Without TOUCH_DRAG_EN, slider updates SHALL occur only on release, and HELD SHALL ignore new_coord.

Structure
REQ-040 Shared package touch_pkg SHALL hold the state enum, the hit-class enum (HIT_NONE, HIT_TEXT, HIT_MINUS, HIT_BAR, HIT_PLUS) and the default geometry constants.
REQ-041 Sub-module touch_debounce SHALL hold the synchroniser, the strobe counter and the release counter, and SHALL output touch_ok, release_ok and a latch strobe.

Verification
REQ-042 Three strobes at (45,23) with pen down, then pen up for 8 cycles -> cell_col=2, cell_row=2, one cell_valid pulse.
REQ-043 A touch at (107,160) -> slide_ch=0, slide_val=47, one write_slide pulse.
REQ-044 Channel 1 preset to 127, then plus at (230,180) -> value stays 127 with write_slide; channel 0 at 0 and minus at (25,160) -> value stays 0.
REQ-045 Two strobes then pen up -> returns to IDLE with no pulses and hit_x unchanged.
REQ-046 iRST_n low during HELD -> all outputs return to reset values and no pulse follows.
REQ-047 With TOUCH_DRAG_EN: a drag on channel 0 over x=40,130,220 -> writes of 0, 63, 127, with no extra write on release.
